mtm_alu_deserializer_p: RTL



---
 rtl/mtm_alu_pkg.sv | 27 ++
 rtl/mtm_alu_frame_rx.sv | 71 +++++++
 rtl/mtm_alu_deserializer_p.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/mtm_alu_pkg.sv
// Shared types and constants for the mtm ALU serial deserializer.
// The CRC4 helper is only referenced when MTM_ALU_DESER_CRC_CHECK_EN is defined.
package mtm_alu_pkg;

   typedef enum logic [1:0] {
      ST_OK        = 2'b00,
      ST_ERR_DATA  = 2'b01,
      ST_ERR_FRAME = 2'b10,
      ST_ERR_CRC   = 2'b11
   } status_t;

   localparam logic DATA = 1'b0;
   localparam logic CMD  = 1'b1;

   localparam int FRAME_BITS = 11;

   // x^4 + x + 1, top term implicit
   localparam logic [3:0] CRC4_POLY = 4'b0011;

   function automatic logic [3:0] crc4_bit(input logic [3:0] crc,
                                           input logic       b);
      logic fb;
      fb = crc[3] ^ b;
      return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
   endfunction

endpackage

// File: rtl/mtm_alu_frame_rx.sv
// Bit-level receiver for 11-bit frames: start, type, 8 payload bits, stop.
// Strobes are registered, so they appear the cycle after the stop bit.
module mtm_alu_frame_rx (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sin,
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
   output logic       bit_en,
`endif
   output logic [7:0] rx_byte,
   output logic       is_cmd,
   output logic       frame_done,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      TYPE,
      PAYLOAD,
      STOP
   } state_t;

   state_t     state;
   state_t     state_n;
   logic [2:0] bit_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE:    if (!sin) state_n = TYPE;
         TYPE:    state_n = PAYLOAD;
         PAYLOAD: if (bit_cnt == 3'd7) state_n = STOP;
         STOP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt    <= '0;
         rx_byte    <= '0;
         is_cmd     <= 1'b0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         frame_done <= (state == STOP) && sin;
         frame_err  <= (state == STOP) && !sin;
         if (state == TYPE) begin
            is_cmd  <= sin;
            bit_cnt <= '0;
         end
         if (state == PAYLOAD) begin
            rx_byte <= {rx_byte[6:0], sin};
            bit_cnt <= bit_cnt + 3'd1;
         end
      end
   end

`ifdef MTM_ALU_DESER_CRC_CHECK_EN
   assign bit_en = (state == PAYLOAD);
`endif

endmodule

// File: rtl/mtm_alu_deserializer_p.sv
// Serial front end for the mtm ALU: frames -> operand packet + status.
// Define MTM_ALU_DESER_CRC_CHECK_EN to enable the CRC4 check on ctl[3:0].
module mtm_alu_deserializer_p #(
   parameter int OPND_BYTES = 4,
   parameter int NUM_OPND   = 2
) (
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               sin,
   output logic                               out_valid,
   input  logic                               out_ready,
   output logic [8*OPND_BYTES*NUM_OPND-1:0]   out_data,
   output logic [7:0]                         out_ctl,
   output logic [1:0]                         out_status,
   output logic                               overrun
);

   import mtm_alu_pkg::*;

   localparam int TOTAL_BYTES = OPND_BYTES * NUM_OPND;
   localparam int W           = 8 * TOTAL_BYTES;
   localparam int CW          = $clog2(TOTAL_BYTES + 1);

   logic [7:0]    rx_byte;
   logic          is_cmd;
   logic          frame_done;
   logic          frame_err;
   logic [CW-1:0] cnt;
   logic          too_many;
   logic [W-1:0]  asm_q;
   logic          crc_bad;
   logic          data_done;
   logic          cmd_done;
   logic          close;
   logic          load;
   status_t       new_st;
   logic [W-1:0]  new_data;
   logic [7:0]    new_ctl;
   status_t       st_q;

`ifdef MTM_ALU_DESER_CRC_CHECK_EN
   logic          bit_en;
`endif

   mtm_alu_frame_rx u_rx (
      .clk        (clk),
      .rst_n      (rst_n),
      .sin        (sin),
`ifdef MTM_ALU_DESER_CRC_CHECK_EN
      .bit_en     (bit_en),
`endif
      .rx_byte    (rx_byte),
      .is_cmd     (is_cmd),
      .frame_done (frame_done),
      .frame_err  (frame_err)
   );

   assign data_done = frame_done && (is_cmd == DATA);
   assign cmd_done  = frame_done && (is_cmd == CMD);
   assign close     = frame_err || cmd_done;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         too_many <= 1'b0;
         asm_q    <= '0;
      end else if (close) begin
         cnt      <= '0;
         too_many <= 1'b0;
         asm_q    <= '0;
      end else if (data_done) begin
         if (cnt == CW'(TOTAL_BYTES)) begin
            too_many <= 1'b1;
         end else begin
            asm_q <= (asm_q << 8) | W'(rx_byte);
            cnt   <= cnt + CW'(1);
         end
      end
   end

`ifdef MTM_ALU_DESER_CRC_CHECK_EN
   logic [3:0] crc;
   logic [3:0] crc_fin;

   // Data bits are folded in as they arrive; the trailer is folded at close.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         crc <= '0;
      end else if (close) begin
         crc <= '0;
      end else if (bit_en && (is_cmd == DATA)) begin
         crc <= crc4_bit(crc, sin);
      end
   end

   always_comb begin
      crc_fin = crc4_bit(crc, 1'b1);
      for (int i = 6; i >= 4; i--) begin
         crc_fin = crc4_bit(crc_fin, rx_byte[i]);
      end
      crc_bad = (crc_fin != rx_byte[3:0]);
   end
`else
   assign crc_bad = 1'b0;
`endif

   always_comb begin
      new_st   = ST_OK;
      new_data = asm_q;
      new_ctl  = rx_byte;
      if (frame_err) begin
         new_st   = ST_ERR_FRAME;
         new_data = '0;
         new_ctl  = '0;
      end else if ((cnt != CW'(TOTAL_BYTES)) || too_many) begin
         new_st   = ST_ERR_DATA;
         new_data = '0;
      end else if (crc_bad) begin
         new_st = ST_ERR_CRC;
      end
   end

   assign load = close && (!out_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ctl   <= '0;
         st_q      <= ST_OK;
         overrun   <= 1'b0;
      end else begin
         overrun <= close && out_valid && !out_ready;
         if (load) begin
            out_valid <= 1'b1;
            out_data  <= new_data;
            out_ctl   <= new_ctl;
            st_q      <= new_st;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   assign out_status = st_q;

endmodule
